// File: rtl/sal_ddr_dfi_responder_if.sv
// DFI ctrl/wr/rd bus between a DDR controller (master) and the PHY+DRAM stand-in (slave).
// Pure wiring; the controller drives command and write data, the responder returns read data.
interface sal_ddr_dfi_responder_if #(
    parameter int DATA_W = 64
);
    logic                  dfi_cs_n;
    logic                  dfi_ras_n;
    logic                  dfi_cas_n;
    logic                  dfi_we_n;
    logic [2:0]            dfi_bank;
    logic [15:0]           dfi_address;
    logic                  dfi_wrdata_en;
    logic [DATA_W-1:0]     dfi_wrdata;
    logic [DATA_W/8-1:0]   dfi_wrdata_mask;
    logic                  dfi_rddata_en;
    logic                  dfi_rddata_valid;
    logic [DATA_W-1:0]     dfi_rddata;

    modport master (
        output dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_bank, dfi_address,
        output dfi_wrdata_en, dfi_wrdata, dfi_wrdata_mask, dfi_rddata_en,
        input  dfi_rddata_valid, dfi_rddata
    );

    modport slave (
        input  dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_bank, dfi_address,
        input  dfi_wrdata_en, dfi_wrdata, dfi_wrdata_mask, dfi_rddata_en,
        output dfi_rddata_valid, dfi_rddata
    );
endinterface

// File: rtl/sal_ddr_dfi_responder.sv
// DFI responder: decodes commands, tracks open rows, stores write bursts, returns read bursts.
// Latency: read beat returned RDLAT cycles after each sampled dfi_rddata_en; writes visible next cycle.
// Backpressure: none on the bus; overflowing queues or data beats without a command set err_o[3] and are dropped.
module sal_ddr_dfi_responder #(
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 4,
    parameter int RDLAT     = 4,
    parameter int QDEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sal_ddr_dfi_responder_if.slave dfi,
    output logic [7:0]             bank_open_o,
    output logic [3:0]             err_o
);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int BASE_W = 9;
    localparam int AW     = BASE_W + BEAT_W;
    localparam int QP_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int MASK_W = DATA_W / 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [QP_W-1:0]   LAST_PTR  = QP_W'(QDEPTH - 1);
    localparam logic [QP_W:0]     FULL_CNT  = (QP_W + 1)'(QDEPTH);

    typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF} cmd_e;

    cmd_e                 cmd;
    logic [7:0]           bank_open;
    logic [2:0]           bank_row [8];
    logic                 bank_hit;
    logic [BASE_W-1:0]    cmd_base;

    logic [BASE_W-1:0]    wq_mem [QDEPTH];
    logic [BASE_W-1:0]    rq_mem [QDEPTH];
    logic [QP_W-1:0]      wq_rd, wq_wr, rq_rd, rq_wr;
    logic [QP_W:0]        wq_cnt, rq_cnt;
    logic                 wq_empty, rq_empty, wq_full, rq_full;
    logic                 wq_push_req, rq_push_req, wq_push, rq_push, wq_pop, rq_pop;
    logic                 wr_do, rd_do;
    logic [BEAT_W-1:0]    wbeat, rbeat;
    logic [AW-1:0]        waddr, raddr;
    logic [3:0]           err_set;

    logic [DATA_W-1:0]    mem [2**AW];
    logic [DATA_W-1:0]    rd_word;
    logic [RDLAT-1:0]     pipe_vld;
    logic [DATA_W-1:0]    pipe_dat [RDLAT];

    function automatic logic [QP_W-1:0] ptr_inc(input logic [QP_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        cmd = CMD_NOP;
        if (!dfi.dfi_cs_n) begin
            case ({dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n})
                3'b011:  cmd = CMD_ACT;
                3'b101:  cmd = CMD_RD;
                3'b100:  cmd = CMD_WR;
                3'b010:  cmd = CMD_PRE;
                3'b001:  cmd = CMD_REF;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    assign bank_hit = bank_open[dfi.dfi_bank];
    assign cmd_base = {dfi.dfi_bank, bank_row[dfi.dfi_bank], dfi.dfi_address[5:3]};

    assign wq_empty = (wq_cnt == '0);
    assign rq_empty = (rq_cnt == '0);
    assign wq_full  = (wq_cnt == FULL_CNT);
    assign rq_full  = (rq_cnt == FULL_CNT);

    // Data beats only consume queue entries pushed in earlier cycles (registered counts).
    assign wr_do  = dfi.dfi_wrdata_en && !wq_empty;
    assign rd_do  = dfi.dfi_rddata_en && !rq_empty;
    assign wq_pop = wr_do && (wbeat == LAST_BEAT);
    assign rq_pop = rd_do && (rbeat == LAST_BEAT);

    assign wq_push_req = (cmd == CMD_WR) && bank_hit;
    assign rq_push_req = (cmd == CMD_RD) && bank_hit;
    assign wq_push     = wq_push_req && (!wq_full || wq_pop);
    assign rq_push     = rq_push_req && (!rq_full || rq_pop);

    assign waddr   = {wq_mem[wq_rd], wbeat};
    assign raddr   = {rq_mem[rq_rd], rbeat};
    assign rd_word = mem[raddr];

    always_comb begin
        err_set    = '0;
        err_set[0] = (cmd == CMD_ACT) && bank_hit;
        err_set[1] = ((cmd == CMD_RD) || (cmd == CMD_WR)) && !bank_hit;
        err_set[2] = (cmd == CMD_REF) && (|bank_open);
        err_set[3] = (wq_push_req && !wq_push) || (rq_push_req && !rq_push) ||
                     (dfi.dfi_wrdata_en && wq_empty) || (dfi.dfi_rddata_en && rq_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_open <= '0;
            for (int i = 0; i < 8; i++) bank_row[i] <= '0;
            err_o <= '0;
        end else begin
            err_o <= err_o | err_set;
            case (cmd)
                CMD_ACT: if (!bank_hit) begin
                    bank_open[dfi.dfi_bank] <= 1'b1;
                    bank_row[dfi.dfi_bank]  <= dfi.dfi_address[2:0];
                end
                CMD_PRE: begin
                    if (dfi.dfi_address[10]) bank_open <= '0;
                    else                     bank_open[dfi.dfi_bank] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bank_open_o = bank_open;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wq_rd <= '0; wq_wr <= '0; wq_cnt <= '0; wbeat <= '0;
            rq_rd <= '0; rq_wr <= '0; rq_cnt <= '0; rbeat <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                wq_mem[i] <= '0;
                rq_mem[i] <= '0;
            end
        end else begin
            if (wq_push) begin
                wq_mem[wq_wr] <= cmd_base;
                wq_wr         <= ptr_inc(wq_wr);
            end
            if (rq_push) begin
                rq_mem[rq_wr] <= cmd_base;
                rq_wr         <= ptr_inc(rq_wr);
            end
            if (wr_do) wbeat <= wbeat + 1'b1;
            if (rd_do) rbeat <= rbeat + 1'b1;
            if (wq_pop) wq_rd <= ptr_inc(wq_rd);
            if (rq_pop) rq_rd <= ptr_inc(rq_rd);
            case ({wq_push, wq_pop})
                2'b10:   wq_cnt <= wq_cnt + 1'b1;
                2'b01:   wq_cnt <= wq_cnt - 1'b1;
                default: ;
            endcase
            case ({rq_push, rq_pop})
                2'b10:   rq_cnt <= rq_cnt + 1'b1;
                2'b01:   rq_cnt <= rq_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage array is deliberately not reset; mask bit 1 protects its byte.
    always_ff @(posedge clk) begin
        if (wr_do) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!dfi.dfi_wrdata_mask[b]) mem[waddr][b*8 +: 8] <= dfi.dfi_wrdata[b*8 +: 8];
            end
        end
    end

    // Fixed-latency read return; dropped beats still produce a valid slot carrying zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < RDLAT; i++) pipe_dat[i] <= '0;
        end else begin
            pipe_vld[0] <= dfi.dfi_rddata_en;
            pipe_dat[0] <= rd_do ? rd_word : '0;
            for (int i = 1; i < RDLAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    assign dfi.dfi_rddata_valid = pipe_vld[RDLAT-1];
    assign dfi.dfi_rddata       = pipe_vld[RDLAT-1] ? pipe_dat[RDLAT-1] : '0;
endmodule

// File: tb/tb_sal_ddr_dfi_responder.sv
// Directed bench for sal_ddr_dfi_responder: write/read bursts, byte masking, error flags, reset.
module tb_sal_ddr_dfi_responder;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] bank_open;
    logic [3:0] err;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [63:0] d [4];
    logic [63:0] exp_rd [4];
    logic [63:0] mod1;

    sal_ddr_dfi_responder_if #(.DATA_W(64)) dfi ();

    sal_ddr_dfi_responder #(
        .DATA_W(64), .BURST_LEN(4), .RDLAT(4), .QDEPTH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dfi        (dfi),
        .bank_open_o(bank_open),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [3:0] c, input logic [2:0] b, input logic [15:0] a);
        {dfi.dfi_cs_n, dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} = c;
        dfi.dfi_bank    = b;
        dfi.dfi_address = a;
        tick();
        {dfi.dfi_cs_n, dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} = 4'b1111;
    endtask

    task automatic wr_beat(input logic [63:0] dat, input logic [7:0] m);
        dfi.dfi_wrdata_en   = 1'b1;
        dfi.dfi_wrdata      = dat;
        dfi.dfi_wrdata_mask = m;
        tick();
        dfi.dfi_wrdata_en   = 1'b0;
    endtask

    // Four back-to-back enables; returns must land exactly 4 cycles later, back-to-back.
    task automatic rd_burst(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_early_vld"}, 64'(dfi.dfi_rddata_valid), 64'd0);
            dfi.dfi_rddata_en = 1'b1;
            tick();
        end
        dfi.dfi_rddata_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_vld"}, 64'(dfi.dfi_rddata_valid), 64'd1);
            chk({tag, "_dat"}, dfi.dfi_rddata, exp_rd[i]);
            tick();
        end
        chk({tag, "_tail_vld"}, 64'(dfi.dfi_rddata_valid), 64'd0);
        chk({tag, "_tail_dat"}, dfi.dfi_rddata, 64'd0);
    endtask

    initial begin
        d[0] = 64'h0123_4567_89AB_CDEF;
        d[1] = 64'hDEAD_BEEF_CAFE_F00D;
        d[2] = 64'h1111_2222_3333_4444;
        d[3] = 64'hA5A5_5A5A_0F0F_F0F0;
        mod1 = {d[1][63:32], 32'hFFFF_FFFF};
        {dfi.dfi_cs_n, dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} = 4'b1111;
        dfi.dfi_bank = '0; dfi.dfi_address = '0;
        dfi.dfi_wrdata_en = 1'b0; dfi.dfi_wrdata = '0; dfi.dfi_wrdata_mask = '0;
        dfi.dfi_rddata_en = 1'b0;

        tick(); tick();
        chk("rst_vld", 64'(dfi.dfi_rddata_valid), 64'd0);
        chk("rst_dat", dfi.dfi_rddata, 64'd0);
        chk("rst_bank", 64'(bank_open), 64'h00);
        chk("rst_err", 64'(err), 64'h0);
        rst_n = 1'b1;
        tick();

        // Basic write then read of bank 2, row 0x15, column 0x08
        cmd(C_ACT, 3'd2, 16'h0015);
        chk("act_b2_bank", 64'(bank_open), 64'h04);
        cmd(C_WR, 3'd2, 16'h0008);
        for (int i = 0; i < 4; i++) wr_beat(d[i], 8'h00);
        chk("wr_err", 64'(err), 64'h0);
        cmd(C_RD, 3'd2, 16'h0008);
        for (int i = 0; i < 4; i++) exp_rd[i] = d[i];
        rd_burst("rd1");

        // Masked overwrite of beat 1: only low four bytes take the new data
        cmd(C_WR, 3'd2, 16'h0008);
        wr_beat(d[0], 8'h00);
        wr_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hF0);
        wr_beat(d[2], 8'h00);
        wr_beat(d[3], 8'h00);
        cmd(C_RD, 3'd2, 16'h0008);
        exp_rd[1] = mod1;
        rd_burst("rd_mask");
        chk("mask_err", 64'(err), 64'h0);

        // Protocol errors
        cmd(C_ACT, 3'd0, 16'h0001);
        chk("act_b0_bank", 64'(bank_open), 64'h05);
        chk("act_b0_err", 64'(err), 64'h0);
        cmd(C_ACT, 3'd0, 16'h0002);
        chk("act_twice_err", 64'(err), 64'h1);
        chk("act_twice_bank", 64'(bank_open), 64'h05);
        cmd(C_RD, 3'd5, 16'h0000);
        chk("rd_idle_err", 64'(err), 64'h3);
        cmd(C_ACT, 3'd1, 16'h0003);
        chk("act_b1_bank", 64'(bank_open), 64'h07);
        cmd(C_REF, 3'd0, 16'h0000);
        chk("ref_open_err", 64'(err), 64'h7);
        chk("ref_bank", 64'(bank_open), 64'h07);
        cmd(C_PRE, 3'd3, 16'h0000);
        chk("pre_idle_bank", 64'(bank_open), 64'h07);
        chk("pre_idle_err", 64'(err), 64'h7);
        cmd(C_PRE, 3'd0, 16'h0400);
        chk("prea_bank", 64'(bank_open), 64'h00);

        // Reset in the middle of a read burst (2 of 4 beats returned)
        cmd(C_ACT, 3'd2, 16'h0015);
        cmd(C_RD, 3'd2, 16'h0008);
        dfi.dfi_rddata_en = 1'b1;
        tick(); tick();
        dfi.dfi_rddata_en = 1'b0;
        tick(); tick();
        chk("mid_vld0", 64'(dfi.dfi_rddata_valid), 64'd1);
        chk("mid_dat0", dfi.dfi_rddata, d[0]);
        tick();
        chk("mid_vld1", 64'(dfi.dfi_rddata_valid), 64'd1);
        chk("mid_dat1", dfi.dfi_rddata, mod1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_vld", 64'(dfi.dfi_rddata_valid), 64'd0);
        chk("mid_rst_err", 64'(err), 64'h0);
        chk("mid_rst_bank", 64'(bank_open), 64'h00);
        rst_n = 1'b1;

        // RD queue must be empty after reset: a lone beat flags err and returns zero
        dfi.dfi_rddata_en = 1'b1;
        tick();
        dfi.dfi_rddata_en = 1'b0;
        chk("rq_empty_err", 64'(err), 64'h8);
        tick(); tick();
        chk("rq_empty_vld_early", 64'(dfi.dfi_rddata_valid), 64'd0);
        tick();
        chk("rq_empty_vld", 64'(dfi.dfi_rddata_valid), 64'd1);
        chk("rq_empty_dat", dfi.dfi_rddata, 64'd0);

        // WR queue overflow: fifth command with no data beats
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        cmd(C_ACT, 3'd4, 16'h0000);
        chk("act_b4_bank", 64'(bank_open), 64'h10);
        for (int i = 0; i < 4; i++) cmd(C_WR, 3'd4, 16'h0000);
        chk("wq_four_err", 64'(err), 64'h0);
        cmd(C_WR, 3'd4, 16'h0000);
        chk("wq_full_err", 64'(err), 64'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
